zeroheti_bus_arb: RTL and testbench
===================================

Name: zeroheti_bus_arb

Overview:
- Two-master, seven-slave system-bus interconnect for the zeroHETI subsystem.
- Arbitrates between the core data port (M0) and the debug system-bus access port (M1) with round-robin priority.
- Decodes the granted address against zeroheti_pkg::AddrMap, forwards the request to one slave, and routes the response back to the originating master.
- Unmapped addresses receive a locally generated error response. At most one transaction is outstanding at any time.

Parameters:
- AddrMap, zeroheti_pkg::AddrMap, type addr_map_t, region table used for decode.
- NumMst, 2, number of masters. Fixed value; any other value is unsupported.
- NumSlv, 7, number of slaves. Slave index order: 0 dbg, 1 imem, 2 dmem, 3 hetic, 4 uart, 5 mtimer, 6 ext.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, asynchronous, active-high.
- m_req_i, in, 2: per-master request.
- m_addr_i, in, 2x32: per-master byte address.
- m_we_i, in, 2: per-master write enable.
- m_be_i, in, 2x4: per-master byte enables.
- m_wdata_i, in, 2x32: per-master write data.
- m_gnt_o, out, 2: per-master grant.
- m_rvalid_o, out, 2: per-master response valid.
- m_rdata_o, out, 2x32: per-master read data.
- m_err_o, out, 2: per-master error flag, qualified by m_rvalid_o.
- s_req_o, out, 7: one-hot slave request.
- s_addr_o, out, 32: shared slave address. Full, unmodified address.
- s_we_o, out, 1: shared write enable.
- s_be_o, out, 4: shared byte enables.
- s_wdata_o, out, 32: shared write data.
- s_gnt_i, in, 7: per-slave grant.
- s_rvalid_i, in, 7: per-slave response valid.
- s_rdata_i, in, 7x32: per-slave read data.

Behaviour:
- Protocol is OBI-style. Masters hold req/addr/we/be/wdata stable until gnt. The address phase completes on req&&gnt. The response is a single rvalid pulse, one or more cycles after gnt.
- Decode is half-open: slave i is selected iff base_i <= addr < last_i. First match wins in index order. No match (for example 0xA114..0xFFFF, or 0xFFFF_FFFF) means unmapped.
- FSM states:
  - IDLE: arbitration open; the selected master's request is forwarded combinationally. s_req_o[dec] = 1 and m_gnt_o[sel] = s_gnt_i[dec]. On a mapped handshake: latch the master and slave index, go to WAIT.
    - Unmapped: no s_req_o; m_gnt_o[sel] = 1 in the same cycle; go to ERR.
  - WAIT: all m_gnt_o = 0 and s_req_o = 0. When s_rvalid_i[lat_slv] is seen: m_rvalid_o[lat_mst] = 1, m_rdata_o[lat_mst] = s_rdata_i[lat_slv], m_err_o = 0; go to IDLE.
  - ERR: m_rvalid_o[lat_mst] = 1, m_err_o[lat_mst] = 1, m_rdata_o = 0 for exactly one cycle; go to IDLE.
- Minimum latency: grant in the cycle of request if the slave grants. Throughput is at most one transaction per 2 cycles, because no grant is issued in WAIT/ERR.
- Arbitration:
  - One requester: that requester wins.
  - Both requesting: the master not granted last wins.
  - The last-granted pointer updates only on an address-phase handshake. Reset value is "M1 last", so M0 wins the first contest.
- Selection lock: once a request is forwarded in IDLE without gnt, the selected master is registered and held until its handshake, even if the other master raises req. This keeps forwarded slave signals stable.
- Unused response lanes: m_rdata_o lanes not being responded to are 0.
- Spurious responses: s_rvalid_i from a non-latched slave, or in IDLE, is ignored.
- Reset values: state IDLE, lock clear, pointer = M1, all m_gnt_o/m_rvalid_o/m_err_o/s_req_o = 0.
- Reset mid-transaction aborts tracking; a later stale rvalid is ignored.

Test Plan:
- M0 reads 0x5004 (dmem), slave 2 grants immediately, rvalid 1 cycle later with 0xDEADBEEF -> s_req_o = 0b0000100; m_rvalid_o[0] with rdata 0xDEADBEEF, err 0.
- M0 and M1 request continuously (imem 0x1000, uart 0xA000) from reset -> grants alternate M0, M1, M0, ...; no grant is issued while a response is outstanding.
- M0 requests mtimer 0xA110, slave 5 withholds gnt 3 cycles; M1 raises req in cycle 1 -> s_addr_o stays 0xA110 and s_req_o[5] stays 1 throughout; M1 is served next.
- M1 writes 0xB000 (unmapped) -> gnt same cycle, no s_req_o; next cycle m_rvalid_o[1] = 1, m_err_o[1] = 1, rdata 0.
- Boundary decode: 0xA113 -> mtimer, 0xA114 -> error, 0x10000 -> ext, 0xFFFF_FFFF -> error.
- Assert rst_i while in WAIT, deassert, then slave 2 pulses rvalid -> no m_rvalid_o; state is IDLE and the next M0 request is granted normally.

Source files
------------

// File: rtl/zeroheti_bus_arb.sv
// zeroHETI system-bus interconnect: two OBI masters, round-robin arbitration,
// region decode onto seven slaves, one outstanding transaction, local error responses.

package zeroheti_pkg;

  localparam int unsigned NumRegions = 7;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] last;
  } addr_rule_t;

  typedef addr_rule_t [NumRegions-1:0] addr_map_t;

  // Half-open regions [base, last); index order is dbg, imem, dmem, hetic, uart, mtimer, ext
  localparam addr_map_t AddrMap = '{
    0: '{base: 32'h0000_0000, last: 32'h0000_1000},
    1: '{base: 32'h0000_1000, last: 32'h0000_5000},
    2: '{base: 32'h0000_5000, last: 32'h0000_9000},
    3: '{base: 32'h0000_9000, last: 32'h0000_A000},
    4: '{base: 32'h0000_A000, last: 32'h0000_A100},
    5: '{base: 32'h0000_A100, last: 32'h0000_A114},
    6: '{base: 32'h0001_0000, last: 32'hFFFF_FFFF}
  };

endpackage

module zeroheti_bus_arb #(
  parameter zeroheti_pkg::addr_map_t AddrMap = zeroheti_pkg::AddrMap,
  parameter int unsigned NumMst = 2,
  parameter int unsigned NumSlv = 7
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumMst-1:0]             m_req_i,
  input  logic [NumMst-1:0][31:0]       m_addr_i,
  input  logic [NumMst-1:0]             m_we_i,
  input  logic [NumMst-1:0][3:0]        m_be_i,
  input  logic [NumMst-1:0][31:0]       m_wdata_i,
  output logic [NumMst-1:0]             m_gnt_o,
  output logic [NumMst-1:0]             m_rvalid_o,
  output logic [NumMst-1:0][31:0]       m_rdata_o,
  output logic [NumMst-1:0]             m_err_o,
  output logic [NumSlv-1:0]             s_req_o,
  output logic [31:0]                   s_addr_o,
  output logic                          s_we_o,
  output logic [3:0]                    s_be_o,
  output logic [31:0]                   s_wdata_o,
  input  logic [NumSlv-1:0]             s_gnt_i,
  input  logic [NumSlv-1:0]             s_rvalid_i,
  input  logic [NumSlv-1:0][31:0]       s_rdata_i
);

  localparam int unsigned SlvIdxW = $clog2(NumSlv);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_e;

  state_e               state_q;
  logic                 lock_q;
  logic                 lock_mst_q;
  logic                 last_q;
  logic                 lat_mst_q;
  logic [SlvIdxW-1:0]   lat_slv_q;

  logic                 sel;
  logic                 hit;
  logic                 hs;
  logic [SlvIdxW-1:0]   dec;

  // Locked master first, then round-robin against the last granted master
  always_comb begin : arb
    if (lock_q) begin
      sel = lock_mst_q;
    end else if (&m_req_i) begin
      sel = ~last_q;
    end else begin
      sel = m_req_i[1];
    end
  end

  // First matching region wins
  always_comb begin : decode
    hit = 1'b0;
    dec = '0;
    for (int unsigned i = 0; i < NumSlv; i++) begin
      if (!hit && (m_addr_i[sel] >= AddrMap[i].base) && (m_addr_i[sel] < AddrMap[i].last)) begin
        hit = 1'b1;
        dec = SlvIdxW'(i);
      end
    end
  end

  assign s_addr_o  = m_addr_i[sel];
  assign s_we_o    = m_we_i[sel];
  assign s_be_o    = m_be_i[sel];
  assign s_wdata_o = m_wdata_i[sel];

  always_comb begin : outputs
    s_req_o    = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_err_o    = '0;
    m_rdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (m_req_i[sel]) begin
          if (hit) begin
            s_req_o[dec] = 1'b1;
            m_gnt_o[sel] = s_gnt_i[dec];
          end else begin
            m_gnt_o[sel] = 1'b1;
          end
        end
      end
      WAIT: begin
        if (s_rvalid_i[lat_slv_q]) begin
          m_rvalid_o[lat_mst_q] = 1'b1;
          m_rdata_o[lat_mst_q]  = s_rdata_i[lat_slv_q];
        end
      end
      ERR: begin
        m_rvalid_o[lat_mst_q] = 1'b1;
        m_err_o[lat_mst_q]    = 1'b1;
      end
      default: ;
    endcase
  end

  assign hs = |m_gnt_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lock_q     <= 1'b0;
      lock_mst_q <= 1'b0;
      last_q     <= 1'b1;
      lat_mst_q  <= 1'b0;
      lat_slv_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            last_q    <= sel;
            lat_mst_q <= sel;
            lat_slv_q <= dec;
            lock_q    <= 1'b0;
            state_q   <= hit ? WAIT : ERR;
          end else if (m_req_i[sel]) begin
            // Hold the forwarded master so slave-side signals stay stable
            lock_q     <= 1'b1;
            lock_mst_q <= sel;
          end
        end
        WAIT: begin
          if (s_rvalid_i[lat_slv_q]) begin
            state_q <= IDLE;
          end
        end
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zeroheti_bus_arb.sv
// Randomized bench for zeroheti_bus_arb: master/slave protocol models drive the bus,
// a monitor compares arbitration, forwarding and responses against a region-table model.

module tb_zeroheti_bus_arb;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [1:0]        m_req_i, m_we_i, m_gnt_o, m_rvalid_o, m_err_o;
  logic [1:0][31:0]  m_addr_i, m_wdata_i, m_rdata_o;
  logic [1:0][3:0]   m_be_i;
  logic [6:0]        s_req_o, s_gnt_i, s_rvalid_i;
  logic [31:0]       s_addr_o, s_wdata_o;
  logic              s_we_o;
  logic [3:0]        s_be_o;
  logic [6:0][31:0]  s_rdata_i;

  always #5 clk = ~clk;

  zeroheti_bus_arb dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
    .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
    .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
  );

  typedef struct {
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Region table: slave i owns [base, lim)
  function automatic int decode(input logic [31:0] a);
    logic [31:0] base [7];
    logic [31:0] lim  [7];
    base = '{32'h0, 32'h1000, 32'h5000, 32'h9000, 32'hA000, 32'hA100, 32'h1_0000};
    lim  = '{32'h1000, 32'h5000, 32'h9000, 32'hA000, 32'hA100, 32'hA114, 32'hFFFF_FFFF};
    for (int i = 0; i < 7; i++) if (a >= base[i] && a < lim[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] slv_data(input int k, input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ (32'(k) << 28);
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 11))
      0:  return 32'h5004;
      1:  return 32'h1000;
      2:  return 32'hA000;
      3:  return 32'hA110;
      4:  return 32'hA113;
      5:  return 32'hA114;
      6:  return 32'h1_0000;
      7:  return 32'hFFFF_FFFF;
      8:  return 32'hB000;
      9:  return 32'($urandom_range(0, 32'hA113));
      10: return 32'($urandom);
      default: return 32'h0FFC;
    endcase
  endfunction

  // ---------------- stimulus: master and slave protocol models ----------------
  bit          outst [2];
  bit          granted [2];
  bit          kill [2];
  int          wcnt [2];
  bit          auto_issue = 0, spur_en = 1, gnt_all = 0, hold_rsp = 0;
  bit          rsp_act = 0;
  int          rsp_slv = 0, rsp_cnt = 0;
  logic [31:0] rsp_data = '0;

  task automatic issue(input int m, input logic [31:0] a);
    exp_t e;
    int   s;
    m_req_i[m]   = 1'b1;
    m_addr_i[m]  = a;
    m_we_i[m]    = 1'($urandom);
    m_be_i[m]    = 4'($urandom);
    m_wdata_i[m] = $urandom;
    s = decode(a);
    e.err  = (s < 0);
    e.data = (s < 0) ? 32'h0 : slv_data(s, a);
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic observe();
    if (rst_i) begin
      for (int m = 0; m < 2; m++) begin
        outst[m] = 0; granted[m] = 0; wcnt[m] = 0;
      end
      rsp_act = 0;
      return;
    end
    for (int m = 0; m < 2; m++) begin
      granted[m] = m_req_i[m] && m_gnt_o[m];
      if (granted[m]) outst[m] = 1;
      if (m_rvalid_o[m]) outst[m] = 0;
      if (m_req_i[m] || outst[m]) wcnt[m]++;
      else wcnt[m] = 0;
      if (wcnt[m] > 60) begin
        chk($sformatf("timeout_m%0d", m), 0, 64'(wcnt[m]), 64'd60);
        kill[m] = 1; outst[m] = 0; wcnt[m] = 0;
      end
    end
    for (int k = 0; k < 7; k++) begin
      if (s_req_o[k] && s_gnt_i[k] && !hold_rsp) begin
        rsp_act  = 1;
        rsp_slv  = k;
        rsp_cnt  = $urandom_range(1, 3);
        rsp_data = slv_data(k, s_addr_o);
      end
    end
  endtask

  task automatic drive();
    int busy;
    int k;
    busy = rsp_act ? rsp_slv : -1;
    s_rvalid_i = '0;
    for (int j = 0; j < 7; j++) s_rdata_i[j] = $urandom;
    if (rsp_act) begin
      if (rsp_cnt <= 1) begin
        s_rvalid_i[rsp_slv] = 1'b1;
        s_rdata_i[rsp_slv]  = rsp_data;
        rsp_act = 0;
      end else begin
        rsp_cnt--;
      end
    end
    // Stray responses from slaves that owe nothing must be ignored
    if (spur_en && $urandom_range(0, 7) == 0) begin
      k = $urandom_range(0, 6);
      if (k != busy) s_rvalid_i[k] = 1'b1;
    end
    s_gnt_i = gnt_all ? 7'h7F : 7'($urandom);
    for (int m = 0; m < 2; m++) begin
      if (granted[m] || kill[m]) begin
        m_req_i[m] = 1'b0; granted[m] = 0; kill[m] = 0;
      end else if (auto_issue && !m_req_i[m] && !outst[m] && $urandom_range(0, 9) < 6) begin
        issue(m, pick_addr());
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit busy_any();
    return (m_req_i != 2'b00) || outst[0] || outst[1] || rsp_act;
  endfunction

  initial begin
    rst_i = 1'b1;
    m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0; m_wdata_i = '0;
    s_gnt_i = '0; s_rvalid_i = '0; s_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {m_gnt_o, m_rvalid_o, m_err_o, s_req_o} == 13'h0,
        64'({m_gnt_o, m_rvalid_o, m_err_o, s_req_o}), 64'h0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    issue(0, pick_addr());
    issue(1, pick_addr());
    auto_issue = 1;
    repeat (1500) tick();
    auto_issue = 0;
    for (int i = 0; i < 200 && busy_any(); i++) tick();
    chk("drain_random", !busy_any(), 64'(busy_any()), 64'h0);

    // Reset while a response is outstanding
    spur_en = 0; gnt_all = 1; hold_rsp = 1;
    s_gnt_i = 7'h7F;
    issue(0, 32'h5004);
    tick();
    tick();
    rst_i = 1'b1;
    m_req_i = '0;
    repeat (2) begin
      @(negedge clk);
      observe();
      chk("reset_mid_txn", {m_gnt_o, m_rvalid_o, m_err_o, s_req_o} == 13'h0,
          64'({m_gnt_o, m_rvalid_o, m_err_o, s_req_o}), 64'h0);
      @(posedge clk);
      #1;
    end
    rst_i = 1'b0;
    s_rvalid_i = 7'b000_0100;
    s_rdata_i[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    observe();
    chk("stale_rvalid", m_rvalid_o == 2'b00, 64'(m_rvalid_o), 64'h0);
    @(posedge clk);
    #1;
    s_rvalid_i = '0;
    hold_rsp = 0;
    issue(0, 32'h5004);
    issue(1, 32'hA000);
    for (int i = 0; i < 50 && busy_any(); i++) tick();
    chk("drain_post_reset", !busy_any(), 64'(busy_any()), 64'h0);
    @(negedge clk);
    chk("scoreboard_empty", (q0.size() + q1.size()) == 0, 64'(q0.size() + q1.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- monitor: arbitration, forwarding, responses ----------------
  initial begin
    bit         open, last, cw_valid, pend, err_due, err_next, reopen;
    int         cw, pend_slv, lat_m, s;
    logic [1:0] exp_rv, exp_gnt;
    logic [6:0] exp_sreq;
    exp_t       e;
    open = 1; last = 1; cw_valid = 0; pend = 0; err_due = 0; err_next = 0;
    cw = 0; pend_slv = 0; lat_m = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        open = 1; last = 1; cw_valid = 0; pend = 0; err_due = 0; err_next = 0;
        q0.delete(); q1.delete();
        continue;
      end
      reopen = 0;
      exp_rv = '0;
      if (err_due || (pend && s_rvalid_i[pend_slv])) exp_rv[lat_m] = 1'b1;
      chk("m_rvalid", m_rvalid_o == exp_rv, 64'(m_rvalid_o), 64'(exp_rv));
      if (exp_rv != 2'b00) begin
        if ((lat_m == 0 ? q0.size() : q1.size()) == 0) begin
          chk("response_without_request", 0, 64'(lat_m), 64'h0);
        end else begin
          e = (lat_m == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("rdata_m%0d", lat_m), m_rdata_o[lat_m] == e.data, 64'(m_rdata_o[lat_m]), 64'(e.data));
          chk($sformatf("err_m%0d", lat_m), m_err_o[lat_m] == e.err, 64'(m_err_o[lat_m]), 64'(e.err));
          chk("rdata_other_lane", m_rdata_o[1-lat_m] == 32'h0, 64'(m_rdata_o[1-lat_m]), 64'h0);
        end
        pend = 0; err_due = 0; reopen = 1;
      end else begin
        chk("rdata_idle", m_rdata_o == 64'h0, 64'(m_rdata_o), 64'h0);
      end

      if (open && m_req_i != 2'b00) begin
        if (!cw_valid) begin
          cw = (m_req_i == 2'b11) ? int'(!last) : (m_req_i[1] ? 1 : 0);
          cw_valid = 1;
        end
        s = decode(m_addr_i[cw]);
        exp_sreq = (s < 0) ? 7'h0 : (7'h1 << s);
        chk("s_req", s_req_o == exp_sreq, 64'(s_req_o), 64'(exp_sreq));
        chk("s_addr", s_addr_o == m_addr_i[cw], 64'(s_addr_o), 64'(m_addr_i[cw]));
        chk("s_fwd", {s_we_o, s_be_o, s_wdata_o} == {m_we_i[cw], m_be_i[cw], m_wdata_i[cw]},
            64'({s_we_o, s_be_o, s_wdata_o}), 64'({m_we_i[cw], m_be_i[cw], m_wdata_i[cw]}));
        exp_gnt = '0;
        if (s < 0 || s_gnt_i[s]) exp_gnt[cw] = 1'b1;
        chk("m_gnt", m_gnt_o == exp_gnt, 64'(m_gnt_o), 64'(exp_gnt));
        if (exp_gnt != 2'b00) begin
          last = cw[0]; lat_m = cw; cw_valid = 0; open = 0;
          if (s < 0) err_next = 1;
          else begin pend = 1; pend_slv = s; end
        end
      end else begin
        chk("no_gnt", m_gnt_o == 2'b00, 64'(m_gnt_o), 64'h0);
      end
      if (reopen) open = 1;
      err_due = err_next;
      err_next = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
